// File: rtl/yarp_wb_arbiter.sv
// yarp_wb_arbiter: arbitrates register-file writes from the execute unit and
// the load unit. Each source owns a one-entry holding slot; at most one slot
// is granted per cycle and the granted entry shows up on the registered
// regfile write port in the following cycle.
module yarp_wb_arbiter #(
    parameter int unsigned ARB_MODE = 0  // 0: fixed priority (load first), 1: round-robin
) (
    input  logic        clk,
    input  logic        reset,

    input  logic        ex_valid_i,
    input  logic [4:0]  ex_rd_i,
    input  logic [31:0] ex_data_i,
    output logic        ex_ready_o,

    input  logic        ld_valid_i,
    input  logic [4:0]  ld_rd_i,
    input  logic [31:0] ld_data_i,
    output logic        ld_ready_o,

    input  logic        d_cache_busy_i,

    output logic        rf_wr_en_o,
    output logic [4:0]  rf_rd_addr_o,
    output logic [31:0] rf_wr_data_o,
    output logic        pending_o
);

    // Holding slots
    logic        ex_v_q,    ex_v_d;
    logic [4:0]  ex_rd_q,   ex_rd_d;
    logic [31:0] ex_data_q, ex_data_d;
    logic        ld_v_q,    ld_v_d;
    logic [4:0]  ld_rd_q,   ld_rd_d;
    logic [31:0] ld_data_q, ld_data_d;

    // Ordering state: ld_older_q set when the ld entry predates the ex entry;
    // last_ld_q set when the most recent grant went to the ld slot.
    logic        ld_older_q, ld_older_d;
    logic        last_ld_q,  last_ld_d;

    // Registered outputs
    logic        wr_en_q,   wr_en_d;
    logic [4:0]  wr_rd_q,   wr_rd_d;
    logic [31:0] wr_data_q, wr_data_d;
    logic        pending_q, pending_d;

    logic ex_elig, ld_elig;
    logic gnt_ex, gnt_ld;
    logic ex_acc, ld_acc;
    logic ex_cap, ld_cap;

    // Grant selection between the two eligible slots
    always_comb begin
        ex_elig = ex_v_q & ~d_cache_busy_i;
        ld_elig = ld_v_q & ~d_cache_busy_i;
        gnt_ex  = 1'b0;
        gnt_ld  = 1'b0;
        if (ex_elig && ld_elig) begin
            if (ex_rd_q == ld_rd_q) begin
                // Same destination: the older write must land first.
                if (ld_older_q) gnt_ld = 1'b1;
                else            gnt_ex = 1'b1;
            end else if (ARB_MODE == 0) begin
                gnt_ld = 1'b1;
            end else if (last_ld_q) begin
                gnt_ex = 1'b1;
            end else begin
                gnt_ld = 1'b1;
            end
        end else begin
            gnt_ex = ex_elig;
            gnt_ld = ld_elig;
        end
    end

    // Handshake: a slot can take a new entry when empty or draining this cycle
    always_comb begin
        ex_ready_o = ~ex_v_q | gnt_ex;
        ld_ready_o = ~ld_v_q | gnt_ld;
        ex_acc     = ex_valid_i & ex_ready_o;
        ld_acc     = ld_valid_i & ld_ready_o;
        // Writes to x0 are accepted but never occupy a slot.
        ex_cap     = ex_acc & (ex_rd_i != 5'd0);
        ld_cap     = ld_acc & (ld_rd_i != 5'd0);
    end

    // Next-state for slots, ordering flags and the write port
    always_comb begin
        ex_v_d     = ex_v_q;
        ex_rd_d    = ex_rd_q;
        ex_data_d  = ex_data_q;
        ld_v_d     = ld_v_q;
        ld_rd_d    = ld_rd_q;
        ld_data_d  = ld_data_q;
        ld_older_d = ld_older_q;
        last_ld_d  = last_ld_q;
        wr_en_d    = gnt_ex | gnt_ld;
        wr_rd_d    = wr_rd_q;
        wr_data_d  = wr_data_q;

        // A capture on the same edge as a grant replaces the drained entry.
        if (ex_cap) begin
            ex_v_d    = 1'b1;
            ex_rd_d   = ex_rd_i;
            ex_data_d = ex_data_i;
        end else if (gnt_ex) begin
            ex_v_d    = 1'b0;
        end

        if (ld_cap) begin
            ld_v_d    = 1'b1;
            ld_rd_d   = ld_rd_i;
            ld_data_d = ld_data_i;
        end else if (gnt_ld) begin
            ld_v_d    = 1'b0;
        end

        // Age is decided at capture against whatever stays in the other slot.
        if (ex_cap && ld_cap) begin
            ld_older_d = 1'b1;
        end else if (ld_cap) begin
            ld_older_d = ~(ex_v_q & ~gnt_ex);
        end else if (ex_cap) begin
            ld_older_d = ld_v_q & ~gnt_ld;
        end

        if (gnt_ex) begin
            wr_rd_d   = ex_rd_q;
            wr_data_d = ex_data_q;
            last_ld_d = 1'b0;
        end else if (gnt_ld) begin
            wr_rd_d   = ld_rd_q;
            wr_data_d = ld_data_q;
            last_ld_d = 1'b1;
        end

        pending_d = ex_v_d | ld_v_d;
    end

    // State registers with asynchronous reset
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ex_v_q     <= 1'b0;
            ex_rd_q    <= '0;
            ex_data_q  <= '0;
            ld_v_q     <= 1'b0;
            ld_rd_q    <= '0;
            ld_data_q  <= '0;
            ld_older_q <= 1'b0;
            last_ld_q  <= 1'b0;
            wr_en_q    <= 1'b0;
            wr_rd_q    <= '0;
            wr_data_q  <= '0;
            pending_q  <= 1'b0;
        end else begin
            ex_v_q     <= ex_v_d;
            ex_rd_q    <= ex_rd_d;
            ex_data_q  <= ex_data_d;
            ld_v_q     <= ld_v_d;
            ld_rd_q    <= ld_rd_d;
            ld_data_q  <= ld_data_d;
            ld_older_q <= ld_older_d;
            last_ld_q  <= last_ld_d;
            wr_en_q    <= wr_en_d;
            wr_rd_q    <= wr_rd_d;
            wr_data_q  <= wr_data_d;
            pending_q  <= pending_d;
        end
    end

    assign rf_wr_en_o   = wr_en_q;
    assign rf_rd_addr_o = wr_rd_q;
    assign rf_wr_data_o = wr_data_q;
    assign pending_o    = pending_q;

endmodule

// File: tb/tb_yarp_wb_arbiter.sv
// Testbench for yarp_wb_arbiter: per-cycle vector table on a fixed-priority
// instance, plus hand-written round-robin streaming and reset sequences.
module tb_yarp_wb_arbiter;

    logic        clk;
    logic        reset;
    logic        ex_valid_i, ld_valid_i, d_cache_busy_i;
    logic [4:0]  ex_rd_i, ld_rd_i;
    logic [31:0] ex_data_i, ld_data_i;

    logic        ex_ready0, ld_ready0, wr_en0, pending0;
    logic [4:0]  rd0;
    logic [31:0] data0;
    logic        ex_ready1, ld_ready1, wr_en1, pending1;
    logic [4:0]  rd1;
    logic [31:0] data1;

    int tests = 0;
    int fails = 0;

    yarp_wb_arbiter #(.ARB_MODE(0)) dut0 (
        .clk(clk), .reset(reset),
        .ex_valid_i(ex_valid_i), .ex_rd_i(ex_rd_i), .ex_data_i(ex_data_i), .ex_ready_o(ex_ready0),
        .ld_valid_i(ld_valid_i), .ld_rd_i(ld_rd_i), .ld_data_i(ld_data_i), .ld_ready_o(ld_ready0),
        .d_cache_busy_i(d_cache_busy_i),
        .rf_wr_en_o(wr_en0), .rf_rd_addr_o(rd0), .rf_wr_data_o(data0), .pending_o(pending0)
    );

    yarp_wb_arbiter #(.ARB_MODE(1)) dut1 (
        .clk(clk), .reset(reset),
        .ex_valid_i(ex_valid_i), .ex_rd_i(ex_rd_i), .ex_data_i(ex_data_i), .ex_ready_o(ex_ready1),
        .ld_valid_i(ld_valid_i), .ld_rd_i(ld_rd_i), .ld_data_i(ld_data_i), .ld_ready_o(ld_ready1),
        .d_cache_busy_i(d_cache_busy_i),
        .rf_wr_en_o(wr_en1), .rf_rd_addr_o(rd1), .rf_wr_data_o(data1), .pending_o(pending1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        ex_v;
        logic [4:0]  ex_rd;
        logic [31:0] ex_d;
        logic        ld_v;
        logic [4:0]  ld_rd;
        logic [31:0] ld_d;
        logic        busy;
        logic        e_exr;
        logic        e_ldr;
        logic        e_wr;
        logic [4:0]  e_rd;
        logic [31:0] e_data;
        logic        e_pend;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic ev, input logic [4:0] er, input logic [31:0] ed,
                         input logic lv, input logic [4:0] lr, input logic [31:0] ldd,
                         input logic b);
        ex_valid_i = ev; ex_rd_i = er; ex_data_i = ed;
        ld_valid_i = lv; ld_rd_i = lr; ld_data_i = ldd;
        d_cache_busy_i = b;
    endtask

    logic [4:0]  got_rd[$];
    logic [31:0] got_data[$];
    logic [4:0]  exp_rd_seq[8];
    int          ie, il;
    logic        er_s, lr_s;

    initial begin
        drive(0, 0, 0, 0, 0, 0, 0);
        reset = 1'b1;
        #12;
        chk("reset_wr_en",   {31'd0, wr_en0},   32'd0);
        chk("reset_rd",      {27'd0, rd0},      32'd0);
        chk("reset_data",    data0,             32'd0);
        chk("reset_pending", {31'd0, pending0}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk); #1;

        //                ex_v rd  data          ld_v rd  data   busy exr ldr wr rd  data          pend
        vecs.push_back('{0, 0, 32'h0,        0, 0, 32'h0,  0,   1,  1,  0, 0, 32'h0,        0}); // idle
        vecs.push_back('{1, 5, 32'hDEADBEEF, 0, 0, 32'h0,  0,   1,  1,  0, 0, 32'h0,        0}); // ex rd5
        vecs.push_back('{0, 0, 32'h0,        0, 0, 32'h0,  0,   1,  1,  0, 0, 32'h0,        1}); // granted
        vecs.push_back('{0, 0, 32'h0,        0, 0, 32'h0,  0,   1,  1,  1, 5, 32'hDEADBEEF, 0}); // write
        vecs.push_back('{0, 0, 32'h0,        0, 0, 32'h0,  0,   1,  1,  0, 5, 32'hDEADBEEF, 0}); // hold
        vecs.push_back('{1, 3, 32'h33,       1, 4, 32'h44, 0,   1,  1,  0, 5, 32'hDEADBEEF, 0}); // both
        vecs.push_back('{0, 0, 32'h0,        0, 0, 32'h0,  0,   0,  1,  0, 5, 32'hDEADBEEF, 1}); // ld wins
        vecs.push_back('{0, 0, 32'h0,        0, 0, 32'h0,  0,   1,  1,  1, 4, 32'h44,       1}); // ex next
        vecs.push_back('{0, 0, 32'h0,        0, 0, 32'h0,  0,   1,  1,  1, 3, 32'h33,       0});
        vecs.push_back('{1, 7, 32'h70,       0, 0, 32'h0,  0,   1,  1,  0, 3, 32'h33,       0}); // ex rd7
        vecs.push_back('{0, 0, 32'h0,        1, 7, 32'h71, 1,   0,  1,  0, 3, 32'h33,       1}); // ld rd7 busy
        vecs.push_back('{0, 0, 32'h0,        0, 0, 32'h0,  1,   0,  0,  0, 3, 32'h33,       1}); // stall
        vecs.push_back('{0, 0, 32'h0,        0, 0, 32'h0,  0,   1,  0,  0, 3, 32'h33,       1}); // older ex
        vecs.push_back('{0, 0, 32'h0,        0, 0, 32'h0,  0,   1,  1,  1, 7, 32'h70,       1});
        vecs.push_back('{0, 0, 32'h0,        0, 0, 32'h0,  0,   1,  1,  1, 7, 32'h71,       0});
        vecs.push_back('{0, 0, 32'h0,        1, 0, 32'h99, 0,   1,  1,  0, 7, 32'h71,       0}); // ld rd0
        vecs.push_back('{0, 0, 32'h0,        1, 0, 32'h98, 0,   1,  1,  0, 7, 32'h71,       0});
        vecs.push_back('{0, 0, 32'h0,        0, 0, 32'h0,  0,   1,  1,  0, 7, 32'h71,       0});
        vecs.push_back('{1, 1, 32'hA1,       0, 0, 32'h0,  0,   1,  1,  0, 7, 32'h71,       0}); // back-to-back
        vecs.push_back('{1, 2, 32'hA2,       0, 0, 32'h0,  0,   1,  1,  0, 7, 32'h71,       1});
        vecs.push_back('{0, 0, 32'h0,        0, 0, 32'h0,  0,   1,  1,  1, 1, 32'hA1,       1});
        vecs.push_back('{0, 0, 32'h0,        0, 0, 32'h0,  0,   1,  1,  1, 2, 32'hA2,       0});

        foreach (vecs[i]) begin
            drive(vecs[i].ex_v, vecs[i].ex_rd, vecs[i].ex_d,
                  vecs[i].ld_v, vecs[i].ld_rd, vecs[i].ld_d, vecs[i].busy);
            @(negedge clk);
            chk($sformatf("v%0d_ex_ready", i), {31'd0, ex_ready0}, {31'd0, vecs[i].e_exr});
            chk($sformatf("v%0d_ld_ready", i), {31'd0, ld_ready0}, {31'd0, vecs[i].e_ldr});
            chk($sformatf("v%0d_wr_en",    i), {31'd0, wr_en0},    {31'd0, vecs[i].e_wr});
            chk($sformatf("v%0d_rd",       i), {27'd0, rd0},       {27'd0, vecs[i].e_rd});
            chk($sformatf("v%0d_data",     i), data0,              vecs[i].e_data);
            chk($sformatf("v%0d_pending",  i), {31'd0, pending0},  {31'd0, vecs[i].e_pend});
            @(posedge clk); #1;
        end

        // Round-robin streaming on the ARB_MODE=1 instance from a fresh reset.
        drive(0, 0, 0, 0, 0, 0, 0);
        reset = 1'b1;
        #3;
        reset = 1'b0;
        @(posedge clk); #1;
        ie = 0; il = 0;
        for (int c = 0; c < 16; c++) begin
            drive(ie < 4, 5'(10 + ie), 32'hE000 + 32'(10 + ie),
                  il < 4, 5'(20 + il), 32'hD000 + 32'(20 + il), 0);
            @(negedge clk);
            er_s = ex_ready1;
            lr_s = ld_ready1;
            if (wr_en1) begin
                got_rd.push_back(rd1);
                got_data.push_back(data1);
            end
            @(posedge clk); #1;
            if (ex_valid_i && er_s) ie++;
            if (ld_valid_i && lr_s) il++;
        end
        exp_rd_seq = '{5'd20, 5'd10, 5'd21, 5'd11, 5'd22, 5'd12, 5'd23, 5'd13};
        chk("rr_write_count", got_rd.size(), 32'd8);
        for (int k = 0; k < 8; k++) begin
            if (k < got_rd.size()) begin
                chk($sformatf("rr_rd_%0d", k), {27'd0, got_rd[k]}, {27'd0, exp_rd_seq[k]});
                chk($sformatf("rr_data_%0d", k), got_data[k],
                    ((exp_rd_seq[k] >= 5'd20) ? 32'hD000 : 32'hE000) + {27'd0, exp_rd_seq[k]});
            end
        end

        // Reset pulsed while both slots hold entries (stall keeps them parked).
        drive(1, 9, 32'h900, 1, 10, 32'hA00, 1);
        @(posedge clk); #1;
        drive(0, 0, 0, 0, 0, 0, 1);
        @(negedge clk);
        chk("full_pending_m0", {31'd0, pending0}, 32'd1);
        chk("full_pending_m1", {31'd0, pending1}, 32'd1);
        chk("full_ex_ready",   {31'd0, ex_ready0}, 32'd0);
        chk("full_ld_ready",   {31'd0, ld_ready0}, 32'd0);
        #2 reset = 1'b1;
        #1;
        chk("rst_wr_en_m0", {31'd0, wr_en0},   32'd0);
        chk("rst_rd_m0",    {27'd0, rd0},      32'd0);
        chk("rst_data_m0",  data0,             32'd0);
        chk("rst_pend_m0",  {31'd0, pending0}, 32'd0);
        chk("rst_rd_m1",    {27'd0, rd1},      32'd0);
        chk("rst_data_m1",  data1,             32'd0);
        chk("rst_pend_m1",  {31'd0, pending1}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            chk($sformatf("post_rst_wr_m0_%0d", c), {31'd0, wr_en0},   32'd0);
            chk($sformatf("post_rst_wr_m1_%0d", c), {31'd0, wr_en1},   32'd0);
            chk($sformatf("post_rst_pend_%0d", c),  {31'd0, pending0 | pending1}, 32'd0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/yarp_wb_arbiter.md
YARP_WB_ARBITER -- requirements
Module: yarp_wb_arbiter

Interface
REQ-001 SHALL have parameter ARB_MODE, default 0, meaning 0 = fixed priority with load first, 1 = round-robin.
REQ-002 SHALL have port clk  input  1  the single clock.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have ports ex_valid_i input 1, ex_rd_i input 5, ex_data_i input 32  execute-unit write request.
REQ-005 SHALL have port ex_ready_o  output  1  execute request accepted when ex_valid_i is high.
REQ-006 SHALL have ports ld_valid_i input 1, ld_rd_i input 5, ld_data_i input 32  load-unit write request.
REQ-007 SHALL have port ld_ready_o  output  1  load request accepted when ld_valid_i is high.
REQ-008 SHALL have port d_cache_busy_i  input  1  stall; blocks all grants.
REQ-009 SHALL have ports rf_wr_en_o output 1, rf_rd_addr_o output 5, rf_wr_data_o output 32  registered regfile write port.
REQ-010 SHALL have port pending_o  output  1  at least one holding slot is occupied.

Function
REQ-011 SHALL hold one entry per source (ex slot, ld slot), each with a valid bit, a 5-bit rd and 32-bit data.
REQ-012 SHALL accept a request on a rising edge where valid_i and ready_o are both high.
REQ-013 SHALL drive each ready_o combinationally as (slot empty) OR (slot granted this cycle).
REQ-014 SHALL accept a request with rd = 0 and discard it: the slot stays empty and no write is issued.
REQ-015 SHALL treat a slot as eligible when its valid bit is set and d_cache_busy_i is low.
REQ-016 SHALL grant at most one eligible slot per cycle.
REQ-017 SHALL, when only one slot is eligible, grant that slot.
REQ-018 SHALL, when both slots are eligible and their rd fields are equal, grant the older slot regardless of ARB_MODE.
REQ-019 SHALL, when both slots are eligible and their rd fields differ, grant the ld slot if ARB_MODE = 0.
REQ-020 SHALL, when both slots are eligible, their rd fields differ and ARB_MODE = 1, grant the slot not granted last; the last-grant flag updates on every grant.
REQ-021 SHALL track age with one flag set at capture: a slot filled while the other slot holds an entry is younger.
REQ-022 SHALL, when both slots are captured on the same edge, treat the ld slot as older.
REQ-023 SHALL, on a grant at edge N, drive rf_wr_en_o = 1 with the granted rd and data during cycle N+1, and clear the granted slot at edge N.
REQ-024 SHALL drive rf_wr_en_o = 0 in any cycle following an edge with no grant; rf_rd_addr_o and rf_wr_data_o then hold their previous values.
REQ-025 SHALL, when a slot is granted and a new request for the same source is accepted on the same edge, leave the slot holding the new entry.
REQ-026 SHALL, while d_cache_busy_i is high, issue no grants, keep both slots unchanged, and drive ready_o high only for an empty slot.
REQ-027 SHALL support a sustained throughput of one write per cycle per source when not stalled and uncontended.
REQ-028 SHALL drive pending_o as the OR of both slot valid bits, registered.

Reset
REQ-029 SHALL, on reset assertion, clear both slots, the age flag and the last-grant flag asynchronously; the last-grant flag resets to ex so that ld wins the first round-robin tie.
REQ-030 SHALL hold rf_wr_en_o = 0, rf_rd_addr_o = 0, rf_wr_data_o = 0 and pending_o = 0 while reset is high.
REQ-031 SHALL discard any held entries when reset asserts mid-operation, with no write issued after reset deasserts.

Verification
REQ-032 SHALL cover this scenario: single ex request, rd = 5, data = 0xDEADBEEF, no stall -> rf_wr_en_o = 1, rd = 5, data = 0xDEADBEEF exactly one cycle after acceptance, for one cycle.
REQ-033 SHALL cover this scenario: ex (rd = 3) and ld (rd = 4) accepted on the same edge, ARB_MODE = 0 -> rd 4 is written, then rd 3 on the next cycle.
REQ-034 SHALL cover this scenario: ARB_MODE = 1 with both sources streaming distinct rd values -> grants alternate ld, ex, ld, ex.
REQ-035 SHALL cover this scenario: ex rd = 7 accepted, then ld rd = 7 accepted while d_cache_busy_i = 1 -> after busy drops, ex data is written before ld data.
REQ-036 SHALL cover this scenario: ld request with rd = 0 -> accepted, ld_ready_o stays high, rf_wr_en_o never asserts, pending_o stays 0.
REQ-037 SHALL cover this scenario: reset pulsed while both slots are full -> all outputs are 0, pending_o = 0, and no write is issued after reset.
